// File: rtl/tenv_clock_pkg.sv
// Shared state encoding and helpers for the programmable clock-divider bank.
package tenv_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Widest duration field sat1 can handle; callers zero-extend into it.
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat1(input logic [SAT_W-1:0] d);
        return (d == '0) ? SAT_W'(1) : d;
    endfunction

endpackage

// File: rtl/tenv_clkdiv_chan.sv
// One programmable clock channel: parks on its init level, runs with shadowed
// high/low durations, and stops only on a toggle that lands on the park level.
module tenv_clkdiv_chan
    import tenv_clock_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_init,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_time_high,
    input  logic [CNT_W-1:0] i_time_low,
    output logic             o_clock,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_shadow_h;
    logic [CNT_W-1:0] r_shadow_l;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_shadow_h_nxt;
    logic [CNT_W-1:0] w_shadow_l_nxt;
    logic [CNT_W-1:0] w_high_sat;
    logic [CNT_W-1:0] w_low_sat;
    logic             r_clock;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;
    logic             w_clock_nxt;
    logic             w_expire;

    assign w_high_sat = CNT_W'(sat1(SAT_W'(i_time_high)));
    assign w_low_sat  = CNT_W'(sat1(SAT_W'(i_time_low)));
    assign w_expire   = (r_count <= CNT_W'(1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // A phase is never cut short: STOP only parks on a toggle that lands on init.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_en) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (i_en) begin
                    w_state_nxt = ST_RUN;
                end else if (w_expire && ((~r_clock) == i_init)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clock_nxt    = r_clock;
        w_count_nxt    = r_count;
        w_shadow_h_nxt = r_shadow_h;
        w_shadow_l_nxt = r_shadow_l;
        case (r_state)
            ST_IDLE: begin
                w_clock_nxt = i_init;
                if (i_en) begin
                    w_shadow_h_nxt = w_high_sat;
                    w_shadow_l_nxt = w_low_sat;
                    w_count_nxt    = i_init ? w_high_sat : w_low_sat;
                end
            end
            ST_RUN, ST_STOP: begin
                if (w_expire) begin
                    w_clock_nxt = ~r_clock;
                    // Fresh durations only at a rising edge while running, so each period is self-consistent.
                    if (!r_clock && (r_state == ST_RUN)) begin
                        w_shadow_h_nxt = w_high_sat;
                        w_shadow_l_nxt = w_low_sat;
                        w_count_nxt    = w_high_sat;
                    end else begin
                        w_count_nxt = r_clock ? r_shadow_l : r_shadow_h;
                    end
                end else begin
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_clock_nxt = r_clock;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clock    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_count    <= '0;
            r_shadow_h <= '0;
            r_shadow_l <= '0;
        end else begin
            r_clock    <= w_clock_nxt;
            r_rise     <= w_clock_nxt & ~r_clock;
            r_fall     <= ~w_clock_nxt & r_clock;
            r_count    <= w_count_nxt;
            r_shadow_h <= w_shadow_h_nxt;
            r_shadow_l <= w_shadow_l_nxt;
        end
    end

    assign o_clock = r_clock;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_busy  = r_busy;

endmodule

// File: rtl/tenv_clkdiv_bank.sv
// Bank of independent programmable clock channels sharing one master clock.
module tenv_clkdiv_bank #(
    parameter int CLOCKS_NUMBER = 2,
    parameter int CNT_W         = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [CLOCKS_NUMBER-1:0]       i_init,
    input  logic [CLOCKS_NUMBER-1:0]       i_en,
    input  logic [CLOCKS_NUMBER*CNT_W-1:0] i_time_high,
    input  logic [CLOCKS_NUMBER*CNT_W-1:0] i_time_low,
    output logic [CLOCKS_NUMBER-1:0]       o_clocks,
    output logic [CLOCKS_NUMBER-1:0]       o_rise,
    output logic [CLOCKS_NUMBER-1:0]       o_fall,
    output logic [CLOCKS_NUMBER-1:0]       o_busy
);

    for (genvar g = 0; g < CLOCKS_NUMBER; g++) begin : g_chan
        tenv_clkdiv_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_init     (i_init[g]),
            .i_en       (i_en[g]),
            .i_time_high(i_time_high[g*CNT_W +: CNT_W]),
            .i_time_low (i_time_low[g*CNT_W +: CNT_W]),
            .o_clock    (o_clocks[g]),
            .o_rise     (o_rise[g]),
            .o_fall     (o_fall[g]),
            .o_busy     (o_busy[g])
        );
    end

endmodule

// File: tb/tb_tenv_clkdiv_bank.sv
// Scoreboard bench for tenv_clkdiv_bank: a time-based reference model queues the
// expected outputs of every master-clock edge and a negedge monitor compares them.
module tb_tenv_clkdiv_bank;

    localparam int N = 2;
    localparam int W = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;

    typedef struct packed {
        logic [N-1:0] clocks;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] busy;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   init = '0;
    logic [N-1:0]   en = '0;
    logic [N*W-1:0] th = '0;
    logic [N*W-1:0] tl = '0;
    logic [N-1:0]   clocks;
    logic [N-1:0]   rise;
    logic [N-1:0]   fall;
    logic [N-1:0]   busy;

    exp_t q[$];
    exp_t monExp;
    int   compared = 0;
    int   mismatched = 0;
    int   monCycle = 0;

    // Reference model state: level, mode and the absolute edge number of the next toggle.
    int mLvl[N];
    int mMode[N];
    int mToggleAt[N];
    int mSh[N];
    int mSl[N];
    int edgeNum = 0;

    tenv_clkdiv_bank #(
        .CLOCKS_NUMBER(N),
        .CNT_W(W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_init     (init),
        .i_en       (en),
        .i_time_high(th),
        .i_time_low (tl),
        .o_clocks   (clocks),
        .o_rise     (rise),
        .o_fall     (fall),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic modelEdge();
        exp_t e;
        int h;
        int l;
        int nl;
        e = '0;
        for (int i = 0; i < N; i++) begin
            h = int'(th[i*W +: W]);
            l = int'(tl[i*W +: W]);
            if (h == 0) h = 1;
            if (l == 0) l = 1;
            if (!rst_n) begin
                mLvl[i]  = 0;
                mMode[i] = M_IDLE;
            end else begin
                nl = mLvl[i];
                if (mMode[i] == M_IDLE) begin
                    nl = int'(init[i]);
                    if (en[i]) begin
                        mMode[i]     = M_RUN;
                        mSh[i]       = h;
                        mSl[i]       = l;
                        mToggleAt[i] = edgeNum + ((nl == 1) ? h : l);
                    end
                end else if (edgeNum == mToggleAt[i]) begin
                    nl = 1 - mLvl[i];
                    if (mMode[i] == M_RUN && nl == 1) begin
                        mSh[i] = h;
                        mSl[i] = l;
                    end
                    mToggleAt[i] = edgeNum + ((nl == 1) ? mSh[i] : mSl[i]);
                    if (mMode[i] == M_RUN && !en[i]) begin
                        mMode[i] = M_STOP;
                    end else if (mMode[i] == M_STOP) begin
                        if (en[i]) mMode[i] = M_RUN;
                        else if (nl == int'(init[i])) mMode[i] = M_IDLE;
                    end
                end else begin
                    if (mMode[i] == M_RUN && !en[i]) mMode[i] = M_STOP;
                    else if (mMode[i] == M_STOP && en[i]) mMode[i] = M_RUN;
                end
                e.clocks[i] = (nl == 1);
                e.rise[i]   = (nl == 1) && (mLvl[i] == 0);
                e.fall[i]   = (nl == 0) && (mLvl[i] == 1);
                e.busy[i]   = (mMode[i] != M_IDLE);
                mLvl[i]     = nl;
            end
        end
        edgeNum++;
        q.push_back(e);
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] ini, input logic [N-1:0] ev,
                                 input logic [W-1:0] h0, input logic [W-1:0] l0,
                                 input logic [W-1:0] h1, input logic [W-1:0] l1, input int n);
        rst_n = r;
        init  = ini;
        en    = ev;
        th    = {h1, h0};
        tl    = {l1, l0};
        repeat (n) begin
            modelEdge();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if ({clocks, rise, fall, busy} !== e) begin
            mismatched++;
            $display("[TB] FAIL outputs cycle %0d: got clocks=%b rise=%b fall=%b busy=%b, expected clocks=%b rise=%b fall=%b busy=%b",
                     monCycle, clocks, rise, fall, busy, e.clocks, e.rise, e.fall, e.busy);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                monExp = q.pop_front();
                checkOutput(monExp);
                monCycle++;
            end
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < N; i++) begin
            mLvl[i] = 0; mMode[i] = M_IDLE; mToggleAt[i] = 0; mSh[i] = 0; mSl[i] = 0;
        end
        // Reset with init=10, then release: ch1 should rise once and park high.
        applyStimulus(1'b0, 2'b10, 2'b00, 0, 0, 0, 0, 3);
        applyStimulus(1'b1, 2'b10, 2'b00, 0, 0, 0, 0, 4);
        // ch0 3/2 divider, then mid-period rewrite to 1/1.
        applyStimulus(1'b1, 2'b10, 2'b01, 3, 2, 0, 0, 13);
        applyStimulus(1'b1, 2'b10, 2'b01, 1, 1, 0, 0, 10);
        // ch1 4/4 parked high; drop en during its low phase.
        applyStimulus(1'b1, 2'b10, 2'b11, 1, 1, 4, 4, 6);
        applyStimulus(1'b1, 2'b10, 2'b01, 1, 1, 4, 4, 14);
        // Zero durations act as 1/1; en bounced during STOP.
        applyStimulus(1'b1, 2'b10, 2'b01, 0, 0, 4, 4, 6);
        applyStimulus(1'b1, 2'b10, 2'b00, 0, 0, 4, 4, 1);
        applyStimulus(1'b1, 2'b10, 2'b01, 0, 0, 4, 4, 4);
        applyStimulus(1'b1, 2'b10, 2'b00, 0, 0, 4, 4, 6);
        // Both running, reset mid-high, then independent restart.
        applyStimulus(1'b1, 2'b00, 2'b11, 5, 5, 6, 3, 9);
        applyStimulus(1'b0, 2'b00, 2'b11, 5, 5, 6, 3, 2);
        applyStimulus(1'b1, 2'b01, 2'b11, 2, 3, 4, 1, 20);
        for (int k = 0; k < 250; k++) begin
            applyStimulus(($urandom_range(0, 39) != 0), 2'($urandom), 2'($urandom),
                          W'($urandom_range(0, 6)), W'($urandom_range(0, 6)),
                          W'($urandom_range(0, 6)), W'($urandom_range(0, 6)),
                          $urandom_range(1, 8));
        end
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
